prio_encoder_drain: RTL and testbench

- Parametrised, registered priority encoder: generalises the fixed 4-input encoder to N inputs with a selectable priority direction.
- Captures an N-bit request vector and emits the binary index of every set bit, one per beat, in priority order, over a valid/ready stream.
- Sits between request-flag sources (interrupt or event lines) and a downstream consumer that services one index at a time.

---
 rtl/encoder_pkg.sv | 35 +++
 rtl/prio_encoder_drain_if.sv | 26 ++
 rtl/prio_enc_comb.sv | 17 +
 rtl/prio_encoder_drain.sv | 113 +++++++++++
 tb/tb_prio_encoder_drain.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/encoder_pkg.sv
// Shared types and helpers for the draining priority encoder.
// Helpers work on a fixed-width vector so one package serves every N up to MAX_N.
package encoder_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int MAX_N = 64;
    localparam int MAX_W = 6;

    typedef logic [MAX_N-1:0] vec_t;

    // Priority index among the low n bits: dir=1 picks the highest set bit,
    // dir=0 the lowest. Returns 0 for an empty vector; callers truncate to W.
    function automatic int unsigned prio_idx(input vec_t vec, input logic dir,
                                             input int unsigned n);
        int unsigned p;
        int unsigned j;
        p = 0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            j = dir ? i : (MAX_N - 1 - i);
            if (j < n && vec[j[MAX_W-1:0]]) begin
                p = j;
            end
        end
        return p;
    endfunction

    function automatic logic popcount_le1(input vec_t vec);
        return (vec & (vec - vec_t'(1))) == '0;
    endfunction

endpackage

// File: rtl/prio_encoder_drain_if.sv
// Request-vector input stream and index output stream of the draining encoder.
interface prio_encoder_drain_if #(parameter int N = 4);

    localparam int W = $clog2(N);

    logic [N-1:0] req;
    logic         msb_first;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] idx;
    logic         none;
    logic         last;
    logic         idx_valid;
    logic         idx_ready;

    modport master (
        output req, msb_first, req_valid, idx_ready,
        input  req_ready, idx, none, last, idx_valid
    );

    modport slave (
        input  req, msb_first, req_valid, idx_ready,
        output req_ready, idx, none, last, idx_valid
    );

endinterface

// File: rtl/prio_enc_comb.sv
// Purely combinational N-input priority encoder with selectable direction.
module prio_enc_comb
    import encoder_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic         dir,
    output logic [W-1:0] idx,
    output logic         any
);

    assign idx = W'(prio_idx(vec_t'(vec), dir, N));
    assign any = |vec;

endmodule

// File: rtl/prio_encoder_drain.sv
// Captures a request vector and streams out the index of every set bit,
// one per beat, in the priority order selected at accept time.
module prio_encoder_drain
    import encoder_pkg::*;
#(
    parameter int N = 4
) (
    input logic                 clk,
    input logic                 rst,
    prio_encoder_drain_if.slave bus
);

    localparam int W = $clog2(N);

    state_t       state_reg, state_next;
    logic [N-1:0] pending_reg, pending_next;
    logic         dir_reg, dir_next;
    logic [W-1:0] idx_reg, idx_next;
    logic         none_reg, none_next;
    logic         last_reg, last_next;
    logic         valid_reg, valid_next;

    logic [N-1:0] enc_vec;
    logic         enc_dir;
    logic [W-1:0] enc_idx;
    logic         enc_any;
    logic [N-1:0] bit_mask;
    logic         accept;
    logic         advance;

    // One shared encoder: it looks at the fresh request while idle and at the
    // remaining pending bits while draining.
    assign enc_vec  = (state_reg == IDLE) ? bus.req : pending_reg;
    assign enc_dir  = (state_reg == IDLE) ? bus.msb_first : dir_reg;
    assign bit_mask = {{(N-1){1'b0}}, 1'b1} << enc_idx;

    prio_enc_comb #(.N(N)) u_enc (
        .vec (enc_vec),
        .dir (enc_dir),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign accept  = (state_reg == IDLE) && bus.req_valid;
    assign advance = (state_reg == DRAIN) && valid_reg && bus.idx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            dir_reg     <= 1'b1;
            idx_reg     <= '0;
            none_reg    <= 1'b0;
            last_reg    <= 1'b0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            dir_reg     <= dir_next;
            idx_reg     <= idx_next;
            none_reg    <= none_next;
            last_reg    <= last_next;
            valid_reg   <= valid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.req_valid) state_next = DRAIN;
            DRAIN:   if (advance && last_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pending_next = pending_reg;
        dir_next     = dir_reg;
        idx_next     = idx_reg;
        none_next    = none_reg;
        last_next    = last_reg;
        valid_next   = valid_reg;
        if (accept) begin
            idx_next     = enc_idx;
            pending_next = bus.req & ~bit_mask;
            dir_next     = bus.msb_first;
            none_next    = !enc_any;
            last_next    = popcount_le1(vec_t'(bus.req));
            valid_next   = 1'b1;
        end else if (advance) begin
            if (last_reg) begin
                valid_next = 1'b0;
                none_next  = 1'b0;
                last_next  = 1'b0;
            end else begin
                // pending still holds the bit being emitted now, so a single
                // remaining bit means this beat is the final one.
                idx_next     = enc_idx;
                pending_next = pending_reg & ~bit_mask;
                last_next    = popcount_le1(vec_t'(pending_reg));
            end
        end
    end

    always_comb begin
        bus.req_ready = (state_reg == IDLE);
        bus.idx       = idx_reg;
        bus.none      = none_reg;
        bus.last      = last_reg;
        bus.idx_valid = valid_reg;
    end

endmodule

// File: tb/tb_prio_encoder_drain.sv
// Scoreboard bench: stimulus pushes expected beats, per-instance monitors pop and compare.
module tb_prio_encoder_drain;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prio_encoder_drain_if #(.N(4)) bus4 ();
    prio_encoder_drain_if #(.N(5)) bus5 ();

    prio_encoder_drain #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    prio_encoder_drain #(.N(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

    int total = 0;
    int bad   = 0;
    logic [9:0] exp4[$];
    logic [9:0] exp5[$];

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    // Reference: list the set bit positions, walk them in the requested order.
    task automatic model_push(input int which, input logic [31:0] v, input logic msb);
        int n;
        int s[$];
        int sz;
        int id;
        logic [9:0] b;
        n = (which == 0) ? 4 : 5;
        for (int i = 0; i < n; i++) if (v[i]) s.push_back(i);
        sz = s.size();
        if (sz == 0) begin
            b = {8'd0, 1'b1, 1'b1};
            if (which == 0) exp4.push_back(b); else exp5.push_back(b);
        end else begin
            for (int k = 0; k < sz; k++) begin
                id = msb ? s[sz-1-k] : s[k];
                b  = {8'(id), 1'b0, (k == sz - 1)};
                if (which == 0) exp4.push_back(b); else exp5.push_back(b);
            end
        end
    endtask

    task automatic set_req(input int which, input logic [31:0] v, input logic msb, input logic vld);
        if (which == 0) begin
            bus4.req = v[3:0]; bus4.msb_first = msb; bus4.req_valid = vld;
        end else begin
            bus5.req = v[4:0]; bus5.msb_first = msb; bus5.req_valid = vld;
        end
    endtask

    task automatic set_ready(input int which, input logic rdy);
        if (which == 0) bus4.idx_ready = rdy; else bus5.idx_ready = rdy;
    endtask

    function automatic int get_rr(input int which);
        return (which == 0) ? int'(bus4.req_ready) : int'(bus5.req_ready);
    endfunction
    function automatic int get_iv(input int which);
        return (which == 0) ? int'(bus4.idx_valid) : int'(bus5.idx_valid);
    endfunction
    function automatic int get_idx(input int which);
        return (which == 0) ? int'(bus4.idx) : int'(bus5.idx);
    endfunction
    function automatic int get_last(input int which);
        return (which == 0) ? int'(bus4.last) : int'(bus5.last);
    endfunction
    function automatic int qsize(input int which);
        return (which == 0) ? exp4.size() : exp5.size();
    endfunction

    task automatic send(input int which, input logic [31:0] v, input logic msb,
                        input int stall, input bit rnd);
        int guard;
        logic [9:0] first;
        guard = 0;
        while (get_rr(which) == 0 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (get_rr(which) == 0) begin
            total++; bad++;
            $display("FAIL req_ready_timeout: got req_ready=0 expected 1 within 50 cycles");
            return;
        end
        check("queue_empty_before_send", qsize(which), 0);
        model_push(which, v, msb);
        first = (which == 0) ? exp4[0] : exp5[0];
        set_ready(which, (stall == 0) ? (rnd ? ($urandom_range(0, 3) != 0) : 1'b1) : 1'b0);
        set_req(which, v, msb, 1'b1);
        @(posedge clk); #1;
        set_req(which, $urandom, 1'($urandom), 1'b0);
        check("first_beat_latency", get_iv(which), 1);
        for (int c = 0; c < stall; c++) begin
            check("stall_idx", get_idx(which), int'(first[9:2]));
            check("stall_last", get_last(which), int'(first[0]));
            @(posedge clk); #1;
        end
        guard = 0;
        while (get_iv(which) != 0 && guard < 200) begin
            set_ready(which, rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            set_req(which, $urandom, 1'($urandom), 1'($urandom));
            @(posedge clk); #1;
            guard++;
        end
        set_req(which, 0, 1'b0, 1'b0);
        check("drain_done", get_iv(which), 0);
        check("req_ready_after_last", get_rr(which), 1);
        check("queue_empty_after_drain", qsize(which), 0);
    endtask

    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst && bus4.idx_valid && bus4.idx_ready) begin
            if (exp4.size() == 0) begin
                total++; bad++;
                $display("FAIL beat4_unexpected: got idx=%0d expected no beat", bus4.idx);
            end else begin
                e = exp4.pop_front();
                $display("n4 beat idx=%0d none=%0d last=%0d", bus4.idx, bus4.none, bus4.last);
                check("beat4_idx", int'(bus4.idx), int'(e[9:2]));
                check("beat4_none", int'(bus4.none), int'(e[1]));
                check("beat4_last", int'(bus4.last), int'(e[0]));
            end
        end
    end

    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst && bus5.idx_valid && bus5.idx_ready) begin
            if (exp5.size() == 0) begin
                total++; bad++;
                $display("FAIL beat5_unexpected: got idx=%0d expected no beat", bus5.idx);
            end else begin
                e = exp5.pop_front();
                $display("n5 beat idx=%0d none=%0d last=%0d", bus5.idx, bus5.none, bus5.last);
                check("beat5_idx", int'(bus5.idx), int'(e[9:2]));
                check("beat5_none", int'(bus5.none), int'(e[1]));
                check("beat5_last", int'(bus5.last), int'(e[0]));
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_req(0, 0, 1'b0, 1'b0); set_ready(0, 1'b0);
        set_req(1, 0, 1'b0, 1'b0); set_ready(1, 1'b0);
        #12;
        check("reset_req_ready", int'(bus4.req_ready), 1);
        check("reset_idx_valid", int'(bus4.idx_valid), 0);
        check("reset_idx", int'(bus4.idx), 0);
        check("reset_none", int'(bus4.none), 0);
        check("reset_last", int'(bus4.last), 0);
        check("reset_req_ready_n5", int'(bus5.req_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        send(0, 32'b1011, 1'b1, 0, 1'b0);
        send(0, 32'b1011, 1'b0, 0, 1'b0);
        send(0, 32'b0000, 1'b1, 0, 1'b0);
        send(0, 32'b1100, 1'b1, 5, 1'b0);
        send(1, 32'b10001, 1'b1, 0, 1'b0);
        send(1, 32'b00000, 1'b0, 0, 1'b0);

        // Reset in the middle of a drain after one beat has gone out.
        set_ready(0, 1'b1);
        model_push(0, 32'b1011, 1'b1);
        set_req(0, 32'b1011, 1'b1, 1'b1);
        @(posedge clk); #1;
        set_req(0, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("pre_reset_idx", int'(bus4.idx), 1);
        rst = 1'b1;
        #1;
        check("reset_mid_idx_valid", int'(bus4.idx_valid), 0);
        check("reset_mid_req_ready", int'(bus4.req_ready), 1);
        check("reset_mid_popped_one", exp4.size(), 2);
        exp4.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_idx_valid", int'(bus4.idx_valid), 0);
        check("post_reset_req_ready", int'(bus4.req_ready), 1);

        for (int i = 0; i < 500; i++) begin
            send(0, $urandom, 1'($urandom), 0, 1'b1);
            send(1, $urandom, 1'($urandom), ($urandom_range(0, 7) == 0) ? 2 : 0, 1'b1);
        end

        repeat (2) @(posedge clk);
        #1;
        check("final_queue4_empty", exp4.size(), 0);
        check("final_queue5_empty", exp5.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
